// File: rtl/ex_wb_writeback_arbiter.sv
// Merges EX forwarded write-backs and LSU load responses onto one regfile write port;
// 1-cycle registered write, LSU wins collisions, ALU results park in an in-order buffer with read bypass.
module ex_wb_writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid_i,
  input  logic                         alu_we_i,
  input  logic [AW-1:0]                alu_waddr_i,
  input  logic [DW-1:0]                alu_wdata_i,
  output logic                         wb_ready_o,
  input  logic                         lsu_valid_i,
  input  logic [AW-1:0]                lsu_waddr_i,
  input  logic [DW-1:0]                lsu_wdata_i,
  output logic                         lsu_block_o,
  output logic                         rf_we_o,
  output logic [AW-1:0]                rf_waddr_o,
  output logic [DW-1:0]                rf_wdata_o,
  input  logic [AW-1:0]                byp_raddr_a_i,
  input  logic [AW-1:0]                byp_raddr_b_i,
  output logic                         byp_hit_a_o,
  output logic                         byp_hit_b_o,
  output logic [DW-1:0]                byp_data_a_o,
  output logic [DW-1:0]                byp_data_b_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;

  logic accept, parked, push, pop;

  assign parked      = (count_q != '0);
  assign wb_ready_o  = (count_q < FULL_C);
  assign lsu_block_o = parked;
  assign accept      = alu_valid_i && alu_we_i && wb_ready_o;
  // Once anything is parked, new ALU results must queue behind it to keep program order.
  assign pop         = !lsu_valid_i && parked;
  assign push        = accept && (lsu_valid_i || parked);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (pop)  rd_d = (rd_q == LAST_C) ? '0 : rd_q + 1'b1;
    if (push) wr_d = (wr_q == LAST_C) ? '0 : wr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (lsu_valid_i) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= lsu_waddr_i;
        rf_wdata_q <= lsu_wdata_i;
      end else if (parked) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= addr_q[rd_q];
        rf_wdata_q <= data_q[rd_q];
      end else if (accept) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= alu_waddr_i;
        rf_wdata_q <= alu_wdata_i;
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

  // Storage is only ever read below count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= alu_waddr_i;
      data_q[wr_q] <= alu_wdata_i;
    end
  end

  logic [PW:0] slot_c;

  always_comb begin
    byp_hit_a_o  = 1'b0;
    byp_hit_b_o  = 1'b0;
    byp_data_a_o = '0;
    byp_data_b_o = '0;
    slot_c       = '0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = 0; i < DEPTH; i++) begin
      slot_c = {1'b0, rd_q} + (PW + 1)'(i);
      if (slot_c >= DEPTH_W) slot_c = slot_c - DEPTH_W;
      if (CW'(i) < count_q) begin
        if (byp_raddr_a_i != '0 && addr_q[slot_c[PW-1:0]] == byp_raddr_a_i) begin
          byp_hit_a_o  = 1'b1;
          byp_data_a_o = data_q[slot_c[PW-1:0]];
        end
        if (byp_raddr_b_i != '0 && addr_q[slot_c[PW-1:0]] == byp_raddr_b_i) begin
          byp_hit_b_o  = 1'b1;
          byp_data_b_o = data_q[slot_c[PW-1:0]];
        end
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_ex_wb_writeback_arbiter.sv
// Bench for ex_wb_writeback_arbiter: directed vector table, reset corner, then random traffic,
// all checked against an in-order scoreboard of parked ALU results and expected regfile writes.
module tb_ex_wb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid_i, alu_we_i;
  logic [AW-1:0] alu_waddr_i;
  logic [DW-1:0] alu_wdata_i;
  logic          wb_ready_o;
  logic          lsu_valid_i;
  logic [AW-1:0] lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_block_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [AW-1:0] byp_raddr_a_i, byp_raddr_b_i;
  logic          byp_hit_a_o, byp_hit_b_o;
  logic [DW-1:0] byp_data_a_o, byp_data_b_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  ex_wb_writeback_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_we_i(alu_we_i),
    .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .wb_ready_o(wb_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_block_o(lsu_block_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .byp_raddr_a_i(byp_raddr_a_i), .byp_raddr_b_i(byp_raddr_b_i),
    .byp_hit_a_o(byp_hit_a_o), .byp_hit_b_o(byp_hit_b_o),
    .byp_data_a_o(byp_data_a_o), .byp_data_b_o(byp_data_b_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lv, la, ld;
    int av, awe, aa, ad;
    int qa, qb;
    int e_rdy, e_hita, e_da, e_hitb;
    int e_we, e_wa, e_wd, e_cnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t alu_q[$];
  ent_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic byp_model(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = alu_q.size() - 1; i >= 0; i--) begin
        if (alu_q[i].a == a) begin
          h = 1'b1;
          d = alu_q[i].d;
          break;
        end
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v, input bit use_tbl);
    int            qs;
    bit            acc;
    logic          h;
    logic [DW-1:0] d;
    ent_t          e;
    lsu_valid_i   = v.lv[0];
    lsu_waddr_i   = AW'(v.la);
    lsu_wdata_i   = DW'(v.ld);
    alu_valid_i   = v.av[0];
    alu_we_i      = v.awe[0];
    alu_waddr_i   = AW'(v.aa);
    alu_wdata_i   = DW'(v.ad);
    byp_raddr_a_i = AW'(v.qa);
    byp_raddr_b_i = AW'(v.qb);
    #1;
    qs = alu_q.size();
    chk("wb_ready", wb_ready_o, qs < DEPTH);
    chk("lsu_block", lsu_block_o, qs != 0);
    chk("count_pre", count_o, qs);
    byp_model(byp_raddr_a_i, h, d);
    chk("byp_hit_a", byp_hit_a_o, h);
    if (h) chk("byp_data_a", byp_data_a_o, d);
    byp_model(byp_raddr_b_i, h, d);
    chk("byp_hit_b", byp_hit_b_o, h);
    if (h) chk("byp_data_b", byp_data_b_o, d);
    if (use_tbl) begin
      chk("t_ready", wb_ready_o, v.e_rdy);
      chk("t_hit_a", byp_hit_a_o, v.e_hita);
      if (v.e_hita != 0) chk("t_data_a", byp_data_a_o, v.e_da);
      chk("t_hit_b", byp_hit_b_o, v.e_hitb);
      if (v.e_hitb != 0) chk("t_data_b", byp_data_b_o, v.e_da);
    end
    acc = (v.av != 0) && (v.awe != 0) && (qs < DEPTH);
    if (acc) alu_q.push_back('{AW'(v.aa), DW'(v.ad)});
    if (v.lv != 0) exp_q.push_back('{AW'(v.la), DW'(v.ld)});
    else if (alu_q.size() != 0) exp_q.push_back(alu_q.pop_front());
    @(posedge clk);
    #1;
    chk("rf_we", rf_we_o, exp_q.size() != 0);
    if (rf_we_o && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rf_waddr", rf_waddr_o, e.a);
      chk("rf_wdata", rf_wdata_o, e.d);
    end
    exp_q.delete();
    chk("count_post", count_o, alu_q.size());
    if (use_tbl) begin
      chk("t_rf_we", rf_we_o, v.e_we);
      if (v.e_we != 0) begin
        chk("t_rf_waddr", rf_waddr_o, v.e_wa);
        chk("t_rf_wdata", rf_wdata_o, v.e_wd);
      end
      chk("t_count", count_o, v.e_cnt);
    end
    @(negedge clk);
  endtask

  vec_t idle_v;

  initial begin
    //           lv la ld       av we aa ad       qa qb rdy ha da    hb we wa wd       cnt
    tbl[0]  = '{0, 0, 0,       1, 1, 5, 'h1234, 0, 0, 1, 0, 0,    0, 1, 5, 'h1234, 0};
    tbl[1]  = '{0, 0, 0,       0, 0, 0, 0,      0, 0, 1, 0, 0,    0, 0, 0, 0,      0};
    tbl[2]  = '{1, 3, 'hAAAA,  1, 1, 4, 'hBBBB, 0, 0, 1, 0, 0,    0, 1, 3, 'hAAAA, 1};
    tbl[3]  = '{0, 0, 0,       0, 0, 0, 0,      0, 0, 1, 0, 0,    0, 1, 4, 'hBBBB, 0};
    tbl[4]  = '{1, 9, 1,       1, 1, 9, 2,      0, 0, 1, 0, 0,    0, 1, 9, 1,      1};
    tbl[5]  = '{0, 0, 0,       0, 0, 0, 0,      9, 0, 1, 1, 2,    0, 1, 9, 2,      0};
    tbl[6]  = '{1, 10, 'hA0,   1, 1, 11, 'hB1,  0, 0, 1, 0, 0,    0, 1, 10, 'hA0,  1};
    tbl[7]  = '{1, 12, 'hA2,   1, 1, 13, 'hB3,  0, 0, 1, 0, 0,    0, 1, 12, 'hA2,  2};
    tbl[8]  = '{1, 14, 'hA4,   1, 1, 15, 'hB5,  0, 0, 0, 0, 0,    0, 1, 14, 'hA4,  2};
    tbl[9]  = '{0, 0, 0,       1, 1, 15, 'hB5,  0, 0, 0, 0, 0,    0, 1, 11, 'hB1,  1};
    tbl[10] = '{0, 0, 0,       1, 1, 15, 'hB5,  0, 0, 1, 0, 0,    0, 1, 13, 'hB3,  1};
    tbl[11] = '{0, 0, 0,       0, 0, 0, 0,      0, 0, 1, 0, 0,    0, 1, 15, 'hB5,  0};
    tbl[12] = '{0, 0, 0,       1, 0, 20, 'h77,  0, 0, 1, 0, 0,    0, 0, 0, 0,      0};
    tbl[13] = '{1, 1, 5,       1, 1, 7, 'h11,   7, 0, 1, 0, 0,    0, 1, 1, 5,      1};
    tbl[14] = '{1, 2, 6,       1, 1, 7, 'h22,   7, 0, 1, 1, 'h11, 0, 1, 2, 6,      2};
    tbl[15] = '{0, 0, 0,       0, 0, 0, 0,      7, 0, 0, 1, 'h22, 0, 1, 7, 'h11,   1};
    tbl[16] = '{0, 0, 0,       0, 0, 0, 0,      7, 7, 1, 1, 'h22, 1, 1, 7, 'h22,   0};
    tbl[17] = '{0, 0, 0,       0, 0, 0, 0,      7, 0, 1, 0, 0,    0, 0, 0, 0,      0};
    tbl[18] = '{1, 3, 1,       1, 1, 0, 'h99,   0, 0, 1, 0, 0,    0, 1, 3, 1,      1};
    tbl[19] = '{0, 0, 0,       0, 0, 0, 0,      0, 0, 1, 0, 0,    0, 1, 0, 'h99,   0};
    idle_v  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    alu_valid_i = 1'b0; alu_we_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    byp_raddr_a_i = '0; byp_raddr_b_i = '0;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_ready", wb_ready_o, 1);
    chk("rst_block", lsu_block_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) step(tbl[i], 1'b1);

    // Fill the park buffer, then reset while it holds two entries.
    step('{1, 1, 'h10, 1, 1, 21, 'hC1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    step('{1, 2, 'h20, 1, 1, 22, 'hC2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    chk("pre_rst_count", count_o, 2);
    lsu_valid_i = 1'b0; alu_valid_i = 1'b0; alu_we_i = 1'b0;
    byp_raddr_a_i = 6'd22; byp_raddr_b_i = 6'd21;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_rf_we", rf_we_o, 0);
    chk("mid_rst_waddr", rf_waddr_o, 0);
    chk("mid_rst_wdata", rf_wdata_o, 0);
    chk("mid_rst_ready", wb_ready_o, 1);
    chk("mid_rst_block", lsu_block_o, 0);
    chk("mid_rst_hit_a", byp_hit_a_o, 0);
    chk("mid_rst_hit_b", byp_hit_b_o, 0);
    chk("mid_rst_data_a", byp_data_a_o, 0);
    alu_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(idle_v, 1'b0);

    // Random traffic; EX holds a refused result like a real pipeline would.
    begin
      vec_t r;
      r = idle_v;
      for (int n = 0; n < 400; n++) begin
        if (!(r.av != 0 && r.awe != 0 && wb_ready_o == 1'b0)) begin
          r.av  = ($urandom_range(0, 9) < 6) ? 1 : 0;
          r.awe = ($urandom_range(0, 9) < 9) ? 1 : 0;
          r.aa  = int'($urandom_range(0, 15));
          r.ad  = int'($urandom);
        end
        r.lv = ($urandom_range(0, 9) < 4) ? 1 : 0;
        r.la = int'($urandom_range(0, 15));
        r.ld = int'($urandom);
        r.qa = int'($urandom_range(0, 15));
        r.qb = int'($urandom_range(0, 15));
        step(r, 1'b0);
      end
    end
    repeat (DEPTH + 2) step(idle_v, 1'b0);
    chk("drain_count", count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_wb_writeback_arbiter.md
Name: ex_wb_writeback_arbiter

Overview:
- Downstream neighbour of the EX stage. Takes the EX forwarded write-back (`regfile_alu_*_fw`) and the LSU load response, and merges them onto a single register-file write port.
- When both arrive in the same cycle, the LSU write wins. The ALU result is parked in a small in-order buffer.
- Back-pressures EX via `wb_ready_o`, blocks new load issue while results are parked, and exposes a read-bypass so ID sees parked values.

Parameters:
- `DEPTH`, 2: ALU park-buffer entries (>=1).
- `AW`, 6: register address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `alu_valid_i` in 1: EX result valid (ex_valid).
- `alu_we_i` in 1: EX result writes regfile.
- `alu_waddr_i` in AW: EX destination.
- `alu_wdata_i` in DW: EX result.
- `wb_ready_o` out 1: block can accept an EX result this cycle.
- `lsu_valid_i` in 1: load response valid; cannot be stalled.
- `lsu_waddr_i` in AW: load destination.
- `lsu_wdata_i` in DW: load data.
- `lsu_block_o` out 1: forbid new load issue.
- `rf_we_o` out 1: regfile write enable.
- `rf_waddr_o` out AW: regfile write address.
- `rf_wdata_o` out DW: regfile write data.
- `byp_raddr_a_i` in AW: bypass query port A address.
- `byp_raddr_b_i` in AW: bypass query port B address.
- `byp_hit_a_o` out 1: port A address matches a parked entry.
- `byp_hit_b_o` out 1: port B address matches a parked entry.
- `byp_data_a_o` out DW: port A data from the youngest matching parked entry.
- `byp_data_b_o` out DW: port B data from the youngest matching parked entry.
- `count_o` out $clog2(DEPTH+1): parked entries.

Behaviour:
- Reset (async, `rst`=1): buffer emptied, `count_o`=0, `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, `wb_ready_o`=1, `lsu_block_o`=0, `byp_hit_*`=0, `byp_data_*`=0. Reset mid-operation discards parked entries without writing them.
- Registered output stage: `rf_*_o` are flops, written one cycle after the selected source is sampled. `byp_*` and `wb_ready_o` are combinational from buffer state.
- Accept rule: an EX result is accepted when `alu_valid_i && alu_we_i && wb_ready_o`. A result with `alu_we_i`=0 is consumed and dropped. `wb_ready_o` = (count < DEPTH).
- Ordering invariant: an LSU response is older than every parked or arriving ALU result. `lsu_block_o` = (count != 0) stops younger loads from issuing until the buffer drains.
- Per-cycle write-port selection, in priority order:
  1. `lsu_valid_i` → write LSU.
  2. else if count>0 → write buffer head, pop.
  3. else if an ALU result is accepted → write it directly (bypasses the buffer).
  4. else `rf_we_o`=0 next cycle.
- Parking: an accepted ALU result is pushed into the buffer when the port is taken by the LSU, or when count>0 (preserves order).
- Simultaneous pop + push in the same cycle: count unchanged; FIFO order kept. Pointers wrap modulo DEPTH.
- Full: `wb_ready_o`=0, so EX must hold its result. An LSU response while full still writes immediately.
- Bypass: search parked entries youngest-first; the first entry whose `waddr` equals the query address gives hit=1 and its data. Address 0 never hits. Entries being popped this cycle still count for bypass.
- Same address in LSU and parked entry: both write in order (LSU first, then the parked value), so the younger ALU value is final.

Test Plan:
- Lone ALU: `alu_valid_i`=1, `waddr`=5, `wdata`=0x1234, no LSU → next cycle `rf_we_o`=1, `waddr`=5, `wdata`=0x1234; `count_o`=0.
- Collision: LSU(`waddr`=3, 0xAAAA) and ALU(`waddr`=4, 0xBBBB) in the same cycle → cycle+1 writes r3=0xAAAA, `count_o`=1, `lsu_block_o`=1. Cycle+2 writes r4=0xBBBB, count=0.
- Full back-pressure, DEPTH=2: LSU valid 3 consecutive cycles with ALU valid each cycle → `wb_ready_o`=0 after 2 pushes. The third ALU result is held by EX and retired in order after the LSU stops.
- Bypass: park r7=0x11 then r7=0x22 → `byp_raddr_a_i`=7 gives hit=1, data=0x22; `byp_raddr_b_i`=0 gives hit=0.
- Same-address order: LSU r9=0x1 collides with ALU r9=0x2 → writes r9=0x1 then r9=0x2.
- Reset mid-operation: `count_o`=2, assert `rst` → all outputs reach reset values immediately; no parked write appears after release.
